// File: rtl/nibble_sort_pkg.sv
// -----------------------------------------------------------------------------
// nibble_sort_pkg
// Shared definitions for the nibble sorter: controller state encoding, element
// geometry, and the widths of the pass/index/swap counters.
// Ports: none (package).
// -----------------------------------------------------------------------------
package nibble_sort_pkg;

    localparam int N_ELEM = 4;
    localparam int ELEM_W = 4;
    localparam int DATA_W = N_ELEM * ELEM_W;
    localparam int IDX_W  = 2;
    localparam int PASS_W = 2;
    localparam int CNT_W  = 3;

    // Last compare position in a pass (compares e[2] with e[3]) and the last
    // pass a four-element bubble sort can ever need.
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ELEM - 2);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N_ELEM - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Element k occupies bits [4k+3:4k], matching the din/dout packing.
    typedef logic [N_ELEM-1:0][ELEM_W-1:0] elem_vec_t;

endpackage

// File: rtl/mag_cmp4.sv
// -----------------------------------------------------------------------------
// mag_cmp4
// Combinational unsigned magnitude comparator for two 4-bit elements.
// Exactly one of less/equal/greater is high for any input pair.
// Ports:
//   a, b     : input  [ELEM_W-1:0]  operands
//   less     : output               a <  b
//   equal    : output               a == b
//   greater  : output               a >  b
// -----------------------------------------------------------------------------
module mag_cmp4
    import nibble_sort_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic              less,
    output logic              equal,
    output logic              greater
);

    assign less    = (a <  b);
    assign equal   = (a == b);
    assign greater = (a >  b);

endmodule

// File: rtl/nibble_sort_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_sort_ctrl
// Sorts four 4-bit elements with a bubble sort that reuses a single magnitude
// comparator, one compare per clock. A pass is three compares (idx 0,1,2);
// the sort ends after a pass with no swap, or after the third pass.
// Parameters:
//   DESCEND  : 0 = ascending (element 0 smallest), 1 = descending
// Ports:
//   clk      : input            rising-edge clock
//   rst_n    : input            synchronous active-low reset
//   start    : input            sort request, only looked at in IDLE
//   din      : input  [15:0]    four elements, element k = din[4k+3:4k]
//   busy     : output           high while compares are running
//   done     : output           one-cycle pulse, dout/swap_cnt valid
//   dout     : output [15:0]    sorted elements, same packing as din
//   swap_cnt : output [2:0]     number of swaps made by the last sort
// -----------------------------------------------------------------------------
module nibble_sort_ctrl
    import nibble_sort_pkg::*;
#(
    parameter bit DESCEND = 1'b0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  swap_cnt
);

    state_t            state, state_nxt;
    elem_vec_t         e, e_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt, idx_p1;
    logic [PASS_W-1:0] pass, pass_nxt;
    logic              pass_swapped, pass_swapped_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              load_out;
    logic [ELEM_W-1:0] cmp_a, cmp_b;
    logic              less, equal, greater;
    logic              do_swap, swapped_now;

    assign idx_p1 = idx + IDX_W'(1);
    assign cmp_a  = e[idx];
    assign cmp_b  = e[idx_p1];

    mag_cmp4 u_cmp (
        .a       (cmp_a),
        .b       (cmp_b),
        .less    (less),
        .equal   (equal),
        .greater (greater)
    );

    // Equal neighbours never swap, which keeps the sort stable.
    assign do_swap     = ~equal & (DESCEND ? less : greater);
    // Swap history of the current pass including the compare in flight,
    // so the last compare of a pass can decide the early exit.
    assign swapped_now = pass_swapped | do_swap;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath next values and status outputs.
    // The result registers load on the transition into DONE so that dout and
    // swap_cnt already hold the new result during the done pulse.
    always_comb begin
        state_nxt        = state;
        e_nxt            = e;
        idx_nxt          = idx;
        pass_nxt         = pass;
        pass_swapped_nxt = pass_swapped;
        cnt_nxt          = cnt;
        load_out         = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    e_nxt            = din;
                    idx_nxt          = '0;
                    pass_nxt         = '0;
                    pass_swapped_nxt = 1'b0;
                    cnt_nxt          = '0;
                    state_nxt        = CMP;
                end
            end

            CMP: begin
                busy = 1'b1;
                if (do_swap) begin
                    e_nxt[idx]       = cmp_b;
                    e_nxt[idx_p1]    = cmp_a;
                    cnt_nxt          = cnt + CNT_W'(1);
                    pass_swapped_nxt = 1'b1;
                end
                if (idx == LAST_IDX) begin
                    if (!swapped_now || (pass == LAST_PASS)) begin
                        state_nxt = DONE;
                        load_out  = 1'b1;
                    end else begin
                        pass_nxt         = pass + PASS_W'(1);
                        idx_nxt          = '0;
                        pass_swapped_nxt = 1'b0;
                    end
                end else begin
                    idx_nxt = idx_p1;
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working registers and the held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e            <= '0;
            idx          <= '0;
            pass         <= '0;
            pass_swapped <= 1'b0;
            cnt          <= '0;
            dout         <= '0;
            swap_cnt     <= '0;
        end else begin
            e            <= e_nxt;
            idx          <= idx_nxt;
            pass         <= pass_nxt;
            pass_swapped <= pass_swapped_nxt;
            cnt          <= cnt_nxt;
            if (load_out) begin
                dout     <= e_nxt;
                swap_cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: doc/nibble_sort_ctrl.md
NIBBLE_SORT_CTRL -- requirements
Module: nibble_sort_ctrl

Interface
REQ-001 Parameter: DESCEND, default 0, sets sort order: 0 = ascending, 1 = descending.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port start, input, 1 bit: request to sort din; sampled only in IDLE.
REQ-005 Port din, input, 16 bits: four unsigned nibbles; element k = din[4k+3:4k].
REQ-006 Port busy, output, 1 bit: high while comparisons are in progress.
REQ-007 Port done, output, 1 bit: one-cycle pulse marking dout and swap_cnt valid.
REQ-008 Port dout, output, 16 bits: sorted result, same element packing as din, registered.
REQ-009 Port swap_cnt, output, 3 bits: number of swaps performed (0..6), registered.

Function
REQ-010 The block SHALL sort four 4-bit elements using exactly one shared magnitude comparator, performing one compare per cycle.
- Comparator outputs: less, equal, greater (e[idx] vs e[idx+1]).
REQ-011 The FSM SHALL have three states: IDLE, CMP, DONE.
REQ-012 In IDLE, when start=1:
- capture din into e[0..3];
- clear idx, pass, pass_swapped and the swap counter;
- go to CMP on the next cycle.
REQ-013 In CMP, each cycle SHALL compare e[idx] with e[idx+1], idx stepping 0, 1, 2.
REQ-014 Swap e[idx] and e[idx+1] when greater=1 (DESCEND=0) or less=1 (DESCEND=1); each swap increments the swap counter and sets pass_swapped.
REQ-015 When equal=1 there SHALL be no swap, so the sort is stable.
REQ-016 At idx=2, the FSM SHALL go to DONE if either:
- no swap occurred in the current pass (including this cycle), or
- pass=2.
Otherwise: pass increments, idx=0, pass_swapped clears, state stays CMP.
REQ-017 In DONE:
- done=1 for exactly one cycle;
- dout and swap_cnt load from e[] and the swap counter in that same cycle;
- the next state is IDLE.
REQ-018 busy SHALL be 1 only in CMP.
REQ-019 Latency: with start sampled at edge T, done is high in cycle T+1+n, where n is the number of compares.
- n = 3 minimum, 9 maximum, always a multiple of 3.
REQ-020 start in CMP or DONE SHALL be ignored, and din changes outside IDLE SHALL have no effect.
REQ-021 dout and swap_cnt SHALL hold their values until the next DONE.
REQ-022 Back-to-back: start asserted in the IDLE cycle immediately after DONE SHALL be accepted.

Reset
REQ-023 When rst_n=0 at a clock edge:
- state = IDLE;
- busy = 0, done = 0, dout = 16'h0000, swap_cnt = 0;
- e[], idx, pass and all counters cleared.
REQ-024 Reset asserted mid-sort SHALL abort it with no done pulse; the first start after rst_n returns high SHALL be serviced normally.

Structure
REQ-025 Shared package nibble_sort_pkg SHALL hold:
- state encoding (IDLE/CMP/DONE);
- N_ELEM=4, ELEM_W=4;
- IDX_W, PASS_W, CNT_W=3.
REQ-026 The comparator SHALL be a separate combinational sub-module mag_cmp4:
- inputs: two 4-bit values;
- outputs: less, equal, greater, exactly one high.
Exactly one instance is permitted.

Verification
REQ-027 Already sorted (DESCEND=0): din=16'h4321 (elements 1,2,3,4) -> 3 compares, done at T+4, dout=16'h4321, swap_cnt=0.
REQ-028 Reversed (DESCEND=0): din=16'h1234 (elements 4,3,2,1) -> 9 compares, done at T+10, dout=16'h4321, swap_cnt=6.
REQ-029 Early exit (DESCEND=0): din=16'h4312 (elements 2,1,3,4) -> 6 compares, done at T+7, dout=16'h4321, swap_cnt=1.
REQ-030 Equal elements and descending mode:
- din=16'h5555 -> done at T+4, dout=16'h5555, swap_cnt=0;
- DESCEND=1, din=16'h4321 -> dout=16'h1234, swap_cnt=6.
REQ-031 Abort and ignored start:
- rst_n low at 3rd CMP cycle -> next cycle busy=0, dout=0, no done pulse;
- start held high during CMP -> exactly one done pulse per accepted start.
